mem_dump_unit: RTL and testbench

MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

---
 rtl/mem_dump_unit.sv | 93 +++++++++
 tb/tb_mem_dump_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_unit.sv
// Dumps a window of data memory as a valid/ready word stream once the
// fetch PC hits END_PC, holding the processor halted from then until reset.
module mem_dump_unit #(
  parameter logic [31:0] END_PC = 32'h90,
  parameter int BASE_WORD = 32,
  parameter int NUM_WORDS = 96,
  parameter int WORDS_PER_LINE = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] PCF,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_eol,
  output logic        dout_last,
  output logic        halt_req,
  output logic        done
);

  localparam logic [9:0] LAST_IDX = 10'(NUM_WORDS - 1);
  localparam logic [9:0] LINE_END = 10'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_idx;
  logic [9:0]  r_col;
  logic [31:0] r_dout;
  logic        w_trig;
  logic        w_hs;
  logic        w_last_idx;
  logic        w_eol_col;

  assign w_trig     = (r_state == S_IDLE) && (PCF == END_PC);
  assign w_hs       = (r_state == S_SEND) && dout_ready;
  assign w_last_idx = (r_idx == LAST_IDX);
  assign w_eol_col  = (r_col == LINE_END);
  assign dm_addr    = 32'(BASE_WORD) + {22'b0, r_idx};

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_trig) w_next = S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND:  if (w_hs) w_next = w_last_idx ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_col tracks position within the output line, avoiding a modulo on idx
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_idx  <= '0;
      r_col  <= '0;
      r_dout <= '0;
    end else begin
      if (w_trig) begin
        r_idx <= '0;
        r_col <= '0;
      end
      if (r_state == S_FETCH) r_dout <= dm_rdata;
      if (w_hs && !w_last_idx) begin
        r_idx <= r_idx + 10'd1;
        r_col <= w_eol_col ? 10'd0 : r_col + 10'd1;
      end
    end
  end

  always_comb begin
    dout       = r_dout;
    dout_valid = (r_state == S_SEND);
    dout_eol   = (r_state == S_SEND) && (w_eol_col || w_last_idx);
    dout_last  = (r_state == S_SEND) && w_last_idx;
    halt_req   = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: full dump, backpressure, retrigger,
// async reset mid-dump, no-trigger sweep and a single-word dump.
module tb_mem_dump_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pcf;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_eol;
  logic        dout_last;
  logic        halt_req;
  logic        done;

  logic        c_clr;
  logic [31:0] c_pcf;
  logic [31:0] c_addr;
  logic [31:0] c_rdata;
  logic [31:0] c_dout;
  logic        c_valid;
  logic        c_ready;
  logic        c_eol;
  logic        c_last;
  logic        c_halt;
  logic        c_done;

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] held;

  always #5 clk = ~clk;

  // memory model: word i holds i*3
  assign dm_rdata = dm_addr * 32'd3;
  assign c_rdata  = c_addr * 32'd3;

  mem_dump_unit u_dut (
    .CLK(clk), .CLR(clr), .PCF(pcf),
    .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_eol(dout_eol),
    .dout_last(dout_last), .halt_req(halt_req),
    .done(done)
  );

  mem_dump_unit #(.NUM_WORDS(1)) u_one (
    .CLK(clk), .CLR(c_clr), .PCF(c_pcf),
    .dm_addr(c_addr), .dm_rdata(c_rdata),
    .dout(c_dout), .dout_valid(c_valid),
    .dout_ready(c_ready), .dout_eol(c_eol),
    .dout_last(c_last), .halt_req(c_halt),
    .done(c_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b0;
    pcf = '0;
    dout_ready = 1'b0;
    c_clr = 1'b0;
    c_pcf = '0;
    c_ready = 1'b0;
    step();
    step();

    chk1("rst_halt", halt_req, 1'b0);
    chk1("rst_valid", dout_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_eol", dout_eol, 1'b0);
    chk1("rst_last", dout_last, 1'b0);
    chk32("rst_dout", dout, 32'd0);
    chk32("rst_addr", dm_addr, 32'd32);

    // PCF sweep below END_PC must never trigger
    clr = 1'b1;
    for (int pc = 0; pc <= 'h8C; pc += 4) begin
      pcf = 32'(pc);
      step();
      chk1("sweep_halt", halt_req, 1'b0);
      chk1("sweep_valid", dout_valid, 1'b0);
    end

    // full dump, ready always high
    pcf = 32'h90;
    dout_ready = 1'b1;
    step();
    pcf = '0;
    chk1("trig_halt", halt_req, 1'b1);
    chk1("trig_valid", dout_valid, 1'b0);
    for (int k = 0; k < 96; k++) begin
      step();
      chk1("a_valid", dout_valid, 1'b1);
      chk32("a_dout", dout, 32'((32 + k) * 3));
      chk1("a_eol", dout_eol, (k % 16) == 15);
      chk1("a_last", dout_last, k == 95);
      step();
      chk1("a_gap", dout_valid, 1'b0);
      chk1("a_done", done, k == 95);
    end

    // DONE is sticky and ignores END_PC
    pcf = 32'h90;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("d_done", done, 1'b1);
      chk1("d_halt", halt_req, 1'b1);
      chk1("d_valid", dout_valid, 1'b0);
    end

    // restart with END_PC held, backpressure on word 7
    clr = 1'b0;
    step();
    chk1("r_done", done, 1'b0);
    clr = 1'b1;
    step();
    chk1("b_halt", halt_req, 1'b1);
    chk32("b_addr0", dm_addr, 32'd32);
    for (int k = 0; k <= 10; k++) begin
      step();
      chk1("b_valid", dout_valid, 1'b1);
      chk32("b_dout", dout, 32'((32 + k) * 3));
      if (k == 7) begin
        dout_ready = 1'b0;
        held = dout;
        for (int s = 0; s < 5; s++) begin
          step();
          chk1("bp_valid", dout_valid, 1'b1);
          chk32("bp_dout", dout, held);
          chk1("bp_eol", dout_eol, 1'b0);
          chk32("bp_addr", dm_addr, 32'd39);
        end
        dout_ready = 1'b1;
      end
      if (k == 10) begin
        // asynchronous reset in the middle of SEND
        dout_ready = 1'b0;
        #2;
        clr = 1'b0;
        #1;
        chk1("ar_valid", dout_valid, 1'b0);
        chk1("ar_halt", halt_req, 1'b0);
        chk1("ar_done", done, 1'b0);
        chk1("ar_eol", dout_eol, 1'b0);
        chk1("ar_last", dout_last, 1'b0);
        chk32("ar_dout", dout, 32'd0);
        chk32("ar_addr", dm_addr, 32'd32);
      end else begin
        step();
        chk1("b_gap", dout_valid, 1'b0);
        chk32("b_addr", dm_addr, 32'(33 + k));
      end
    end

    // new trigger after reset restarts from word 0
    step();
    clr = 1'b1;
    dout_ready = 1'b1;
    step();
    chk1("rs_halt", halt_req, 1'b1);
    chk32("rs_addr", dm_addr, 32'd32);
    step();
    chk1("rs_valid", dout_valid, 1'b1);
    chk32("rs_dout", dout, 32'd96);
    pcf = '0;

    // single-word dump
    c_clr = 1'b1;
    c_pcf = 32'h90;
    c_ready = 1'b1;
    step();
    c_pcf = '0;
    chk1("one_halt", c_halt, 1'b1);
    step();
    chk1("one_valid", c_valid, 1'b1);
    chk32("one_dout", c_dout, 32'd96);
    chk1("one_eol", c_eol, 1'b1);
    chk1("one_last", c_last, 1'b1);
    step();
    chk1("one_done", c_done, 1'b1);
    chk1("one_gap", c_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
